// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the parameterised Johnson (twisted-ring) counter.
//   JC_MAX_N        : widest counter that may be instantiated (bits)
//   jc_phase_width  : width of the phase index for an N-bit counter, i.e.
//                     enough bits to hold 0..2N-1
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int JC_MAX_N = 32;

  function automatic int jc_phase_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage : johnson_pkg

// File: rtl/johnson_phase_decode.sv
// -----------------------------------------------------------------------------
// johnson_phase_decode
// Combinational decode of a Johnson counter state.
//   N        : counter width (2..JC_MAX_N)
//   q_i      : current counter state
//   phase_o  : position of q_i in the 2N-state sequence (0..2N-1)
//   wrap_o   : high when q_i is the last state of the cycle (MSB only set)
//   legal_o  : high when q_i is one of the 2N ring codes
// Optional build macro: JOHNSON_SELF_CORRECT_EN -- when defined, phase_o
// reads 0 for any illegal state.
// -----------------------------------------------------------------------------
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                  q_i,
  output logic [jc_phase_width(N)-1:0]  phase_o,
  output logic                          wrap_o,
  output logic                          legal_o
);

  localparam int PW = jc_phase_width(N);
  localparam logic [N-1:0] WRAP_CODE = {1'b1, {(N-1){1'b0}}};

  // One bit per adjacent pair that differs. A legal Johnson code is a single
  // block of ones anchored at one end, so it has at most one such boundary.
  logic [N-2:0] boundary;

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_boundary
      assign boundary[gi] = q_i[gi] ^ q_i[gi+1];
    end
  endgenerate

  int ones_cnt;
  int boundary_cnt;
  int phase_raw;

  always_comb begin
    ones_cnt     = 0;
    boundary_cnt = 0;
    phase_raw    = 0;

    for (int i = 0; i < N; i++) begin
      if (q_i[i]) ones_cnt = ones_cnt + 1;
    end
    for (int i = 0; i < N - 1; i++) begin
      if (boundary[i]) boundary_cnt = boundary_cnt + 1;
    end

    // Filling half (ones grow from the LSB) counts up with the popcount;
    // draining half (zeros grow from the LSB) counts on from N toward 2N-1.
    // In the draining half q is non-zero, so 2N - ones never exceeds 2N-1.
    if ((q_i == '0) || q_i[0]) begin
      phase_raw = ones_cnt;
    end else begin
      phase_raw = 2 * N - ones_cnt;
    end

    legal_o = (boundary_cnt <= 1);
    phase_o = PW'(phase_raw);
`ifdef JOHNSON_SELF_CORRECT_EN
    if (!legal_o) phase_o = '0;
`endif
    wrap_o = (q_i == WRAP_CODE);
  end

endmodule : johnson_phase_decode

// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
// N-bit Johnson (twisted-ring) counter: every clock the state shifts toward
// the MSB with the inverted MSB fed into the LSB, giving a 2N-state cycle.
//   N      : counter width, 2..JC_MAX_N (default 4)
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; loads all-zeros
//   q      : registered counter state
//   phase  : index of q in the 0..2N-1 sequence (combinational from q)
//   wrap   : high while q is the last state (MSB only set), combinational
// Optional build macro: JOHNSON_SELF_CORRECT_EN -- when defined, an illegal
// state is replaced by all-zeros on the next edge and phase reads 0 while
// the state is illegal. Without it the pure shift equation is used.
// -----------------------------------------------------------------------------
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [N-1:0]                  q,
  output logic [jc_phase_width(N)-1:0]  phase,
  output logic                          wrap
);

  // An out-of-range width references a module that does not exist, so the
  // mistake stops elaboration instead of producing a silently broken counter.
  generate
    if ((N < 2) || (N > JC_MAX_N)) begin : g_bad_width
      johnson_counter_width_out_of_range u_bad_width ();
    end
  endgenerate

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] shift_next;
  logic         state_legal;

  johnson_phase_decode #(
    .N (N)
  ) u_decode (
    .q_i     (q_q),
    .phase_o (phase),
    .wrap_o  (wrap),
    .legal_o (state_legal)
  );

  assign shift_next = {q_q[N-2:0], ~q_q[N-1]};

`ifdef JOHNSON_SELF_CORRECT_EN
  // Any code off the ring collapses to zero, which is on the ring.
  assign q_d = state_legal ? shift_next : '0;
`else
  // Legality only steers the next state when self-correction is built in.
  logic unused_state_legal;
  assign unused_state_legal = state_legal;
  assign q_d = shift_next;
`endif

  // Reset outranks correction: it always wins on the sampled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : johnson_counter_param

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

  logic clk;
  logic reset;

  logic [3:0]  q4;
  logic [2:0]  ph4;
  logic        wr4;
  logic [7:0]  q8;
  logic [3:0]  ph8;
  logic        wr8;
  logic [15:0] q16;
  logic [4:0]  ph16;
  logic        wr16;
  logic [31:0] q32;
  logic [5:0]  ph32;
  logic        wr32;

  int pass_cnt  = 0;
  int total_cnt = 0;

  johnson_counter_param #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .q(q4), .phase(ph4), .wrap(wr4));
  johnson_counter_param #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .q(q8), .phase(ph8), .wrap(wr8));
  johnson_counter_param #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .q(q16), .phase(ph16), .wrap(wr16));
  johnson_counter_param #(.N(32)) dut32 (
    .clk(clk), .reset(reset), .q(q32), .phase(ph32), .wrap(wr32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive reset away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] q;
    logic [2:0] ph;
    logic       wr;
  } vec_t;

  vec_t vecs[13];

  logic [3:0] ring[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first_zero8;
    int first_zero16;
    int first_zero32;
    int wraps8;
    int wraps16;
    int wraps32;

    reset = 1'b1;

    //           rst   q        phase  wrap
    vecs[0]  = '{1'b1, 4'b0000, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0011, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 4'b0111, 3'd3, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 3'd4, 1'b0};
    vecs[6]  = '{1'b0, 4'b1110, 3'd5, 1'b0};
    vecs[7]  = '{1'b0, 4'b1100, 3'd6, 1'b0};
    vecs[8]  = '{1'b0, 4'b1000, 3'd7, 1'b1};
    vecs[9]  = '{1'b0, 4'b0000, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 4'b0001, 3'd1, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 4'b0000, 3'd0, 1'b0};

    // N=4 sequence, wrap-around and mid-sequence reset.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst);
      $display("vec %0d: reset=%0b q=%b phase=%0d wrap=%0b", i, vecs[i].rst, q4, ph4, wr4);
      chk($sformatf("n4_q[%0d]", i), 64'(q4), 64'(vecs[i].q));
      chk($sformatf("n4_phase[%0d]", i), 64'(ph4), 64'(vecs[i].ph));
      chk($sformatf("n4_wrap[%0d]", i), 64'(wr4), 64'(vecs[i].wr));
    end

    // Wider counters from a shared reset over 64 edges.
    first_zero8 = 0; first_zero16 = 0; first_zero32 = 0;
    wraps8 = 0; wraps16 = 0; wraps32 = 0;
    step(1'b1);
    for (int e = 1; e <= 64; e++) begin
      step(1'b0);
      $display("edge %0d: q8=%h q16=%h q32=%h", e, q8, q16, q32);
      if (q8 == '0 && first_zero8 == 0) first_zero8 = e;
      if (q16 == '0 && first_zero16 == 0) first_zero16 = e;
      if (q32 == '0 && first_zero32 == 0) first_zero32 = e;
      if (wr8) wraps8++;
      if (wr16) wraps16++;
      if (wr32) wraps32++;
      if (e == 8) begin
        chk("n8_ones_at_N", 64'(q8), 64'(8'hFF));
        chk("n8_phase_at_N", 64'(ph8), 64'd8);
      end
      if (e == 15) chk("n8_wrap_at_15", 64'(wr8), 64'd1);
      if (e == 16) chk("n16_ones_at_N", 64'(q16), 64'(16'hFFFF));
      if (e == 32) chk("n32_ones_at_N", 64'(q32), 64'(32'hFFFF_FFFF));
      if (e == 63) chk("n32_phase_at_63", 64'(ph32), 64'd63);
    end
    chk("n8_period", 64'(first_zero8), 64'd16);
    chk("n16_period", 64'(first_zero16), 64'd32);
    chk("n32_period", 64'(first_zero32), 64'd64);
    chk("n8_wraps", 64'(wraps8), 64'd4);
    chk("n16_wraps", 64'(wraps16), 64'd2);
    chk("n32_wraps", 64'(wraps32), 64'd1);

    // N=8 reset asserted at 11111000, held, then released.
    step(1'b1);
    for (int e = 0; e < 11; e++) step(1'b0);
    $display("pre-reset: q8=%b", q8);
    chk("n8_pre_reset", 64'(q8), 64'(8'hF8));
    step(1'b1);
    $display("reset edge 1: q8=%b", q8);
    chk("n8_reset_q", 64'(q8), 64'd0);
    chk("n8_reset_phase", 64'(ph8), 64'd0);
    chk("n8_reset_wrap", 64'(wr8), 64'd0);
    step(1'b1);
    $display("reset edge 2: q8=%b", q8);
    chk("n8_reset_held", 64'(q8), 64'd0);
    step(1'b0);
    $display("resume: q8=%b", q8);
    chk("n8_resume", 64'(q8), 64'h01);

    // Reset pulse entirely between edges must be ignored.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    $display("glitch: q8=%b q4=%b", q8, q4);
    chk("n8_async_ignored", 64'(q8), 64'h03);
    chk("n4_async_ignored", 64'(q4), 64'(4'b0011));

    // Illegal ring produced by the bare shift equation for N=4.
    ring[0] = 4'b0101; ring[1] = 4'b1011; ring[2] = 4'b0110; ring[3] = 4'b1101;
    ring[4] = 4'b1010; ring[5] = 4'b0100; ring[6] = 4'b1001; ring[7] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] forced_val;
      logic [3:0] exp_next;
      forced_val = ring[i];
      @(negedge clk);
      force dut4.q_q = forced_val;
      #1;
`ifdef JOHNSON_SELF_CORRECT_EN
      exp_next = 4'b0000;
      chk($sformatf("illegal_phase[%0d]", i), 64'(ph4), 64'd0);
`else
      exp_next = ring[(i + 1) % 8];
`endif
      $display("illegal %b: next=%b legal=%0b", forced_val, dut4.q_d, dut4.u_decode.legal_o);
      chk($sformatf("illegal_next[%0d]", i), 64'(dut4.q_d), 64'(exp_next));
      chk($sformatf("illegal_flag[%0d]", i), 64'(dut4.u_decode.legal_o), 64'd0);
      chk($sformatf("illegal_wrap[%0d]", i), 64'(wr4), 64'd0);
    end
    release dut4.q_q;

    step(1'b1);
    $display("recover: q4=%b", q4);
    chk("n4_recover_reset", 64'(q4), 64'd0);
    step(1'b0);
    $display("recover: q4=%b", q4);
    chk("n4_recover_step", 64'(q4), 64'(4'b0001));
    chk("n4_recover_legal", 64'(dut4.u_decode.legal_o), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_johnson_counter_param
